vga_sprite_engine: RTL
======================

// Module: vga_sprite_engine
// PURPOSE
//  Parametrised VGA timing generator with one keyboard-steered, loadable bitmap sprite.
//  Sits between the PS/2 scan-code receiver (decoded key strobes) and the board VGA pins.
//  Generalises the fixed 640x480 single-figure demo: timing, sprite size, colour depth,
//  step and edge mode are parameters; the bitmap is runtime-writable.
// PARAMETERS
//  CLK_DIV     4    CLK100MHz cycles per pixel (pix_en strobe period, >=2)
//  H_PIX 640, H_FP 16, H_PULSE 96, H_BP 48, H_POL 0   horizontal timing, sync polarity
//  V_PIX 480, V_FP 10, V_PULSE 2,  V_BP 33, V_POL 1   vertical timing, sync polarity
//  CW          3    bits per colour channel
//  SPR_SZ      20   sprite width = height in pixels (<=32)
//  STEP        1    pixels moved per frame per active axis
//  INIT_X/INIT_Y 310/230  sprite top-left after reset
//  SPR_COLOR   {3'd7,3'd0,3'd7}  RGB of set bitmap pixels
// PORTS
//  CLK100MHz   in   1          system clock
//  reset       in   1          synchronous, active-high
//  key_valid   in   1          one-cycle strobe: key_code valid
//  key_code    in   8          scan code (set 2)
//  key_ext     in   1          code was preceded by 0xE0
//  key_rel     in   1          code was preceded by 0xF0 (release)
//  bounce      in   1          1: reverse at edge; 0: stop axis at edge
//  bm_we       in   1          bitmap row write strobe
//  bm_row      in   5          bitmap row index (0..SPR_SZ-1; larger ignored)
//  bm_data     in   SPR_SZ     row bits, bit SPR_SZ-1 = leftmost pixel
//  vga_r/g/b   out  CW each    pixel colour
//  vga_hs      out  1          H-sync
//  vga_vs      out  1          V-sync
//  frame_start out  1          one-cycle pulse, first pix_en of line V_PIX (start of vblank)
// BEHAVIOUR
//  - Reset: counters h=v=0, divider 0, sprite at INIT_X/INIT_Y, dir_x=dir_y=0, bitmap
//    all zero, colours 0, hs=~H_POL, vs=~V_POL, frame_start=0. Reset mid-frame restarts at h=v=0.
//  - pix_en high one cycle every CLK_DIV cycles; all counters/outputs update only on pix_en.
//  - h counts 0..H_FRAME-1 (H_FRAME=sum of H_*), wraps and increments v; v wraps at V_FRAME-1.
//  - hs = H_POL when H_PIX+H_FP <= h < H_PIX+H_FP+H_PULSE, else ~H_POL; vs likewise on v.
//  - Outputs registered: colour/sync reflect (h,v) of the previous pix_en (1 pixel latency).
//  - Colour: outside visible area 0; inside sprite box (x<=h<x+SPR_SZ, y<=v<y+SPR_SZ) with
//    bitmap[v-y][SPR_SZ-1-(h-x)]=1 -> SPR_COLOR; otherwise background 0.
//  - Keys act only when key_valid & key_ext & ~key_rel; 0x75 up, 0x72 down, 0x6B left, 0x74 right.
//    Press sets that axis direction (overrides opposite). Pressing the already-active
//    direction additionally zeroes the other axis. Other codes ignored.
//  - Motion: on frame_start each axis with dir!=0 moves by STEP, clamped to
//    0..H_PIX-SPR_SZ (x) and 0..V_PIX-SPR_SZ (y). Reaching a limit: bounce=1 -> dir negated;
//    bounce=0 -> dir cleared. Key strobe coinciding with frame_start: move uses old dir,
//    key result wins for the new dir.
//  - Bitmap write takes effect next cycle; a write during active video may tear one frame.
//  - Arithmetic: positions unsigned, width clog2(H_FRAME)/clog2(V_FRAME); no wraparound
//    below 0 (clamp checks before subtract).
// CONFIGURATION
//  VGA_BORDER_EN defined: visible pixels on h=0, h=H_PIX-1, v=0, v=V_PIX-1 output full red
//    {all-ones,0,0}, drawn over the sprite. Undefined: no border, those pixels follow sprite/bg.
// TESTING
//  1. Reset, run 2 frames, defaults: hs low for 96 px, period 800 px; vs high for 2 lines,
//     period 525 lines; pix_en period 4 clocks; frame_start once per 420000 pix_en.
//  2. Write row 0 = 20'h80001, sprite at 310/230: pixel (310,230) and (329,230) = 7/0/7,
//     (311,230) = 0; output appears one pix_en after counter position.
//  3. key 0x74 ext press, bounce=0: x increments 1 per frame; stops at 620, dir_x cleared.
//  4. bounce=1, dir left from x=1, STEP=1: frame1 x=0, dir_x becomes +1; frame2 x=1.
//  5. Press right then right again while dir_y=-1: dir_y -> 0, dir_x stays +1; key_rel=1 ignored.
//  6. Assert reset mid-line (h=400,v=100): next cycle h=v=0, sprite at 310/230, colours 0;
//     with VGA_BORDER_EN pixel (0,0) = 7/0/0, without it = 0.

Source files
------------

// File: rtl/vga_sprite_engine.sv
// VGA timing generator with one keyboard-steered, runtime-loadable bitmap sprite.
// Optional build macro VGA_BORDER_EN: draws a full-red one-pixel frame around the visible area.
module vga_sprite_engine #(
    parameter int CLK_DIV = 4,
    parameter int H_PIX = 640, H_FP = 16, H_PULSE = 96, H_BP = 48,
    parameter bit H_POL = 1'b0,
    parameter int V_PIX = 480, V_FP = 10, V_PULSE = 2, V_BP = 33,
    parameter bit V_POL = 1'b1,
    parameter int CW = 3,
    parameter int SPR_SZ = 20,
    parameter int STEP = 1,
    parameter int INIT_X = 310,
    parameter int INIT_Y = 230,
    parameter logic [3*CW-1:0] SPR_COLOR = {3'd7, 3'd0, 3'd7}
) (
    input  logic              CLK100MHz,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [7:0]        key_code,
    input  logic              key_ext,
    input  logic              key_rel,
    input  logic              bounce,
    input  logic              bm_we,
    input  logic [4:0]        bm_row,
    input  logic [SPR_SZ-1:0] bm_data,
    output logic [CW-1:0]     vga_r,
    output logic [CW-1:0]     vga_g,
    output logic [CW-1:0]     vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              frame_start
);
    localparam int H_FRAME = H_PIX + H_FP + H_PULSE + H_BP;
    localparam int V_FRAME = V_PIX + V_FP + V_PULSE + V_BP;
    localparam int HW = $clog2(H_FRAME);
    localparam int VW = $clog2(V_FRAME);
    localparam int DW = $clog2(CLK_DIV);
    localparam int SW = $clog2(SPR_SZ);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_FRAME - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_PIX);
    localparam logic [HW-1:0] H_VLAST  = HW'(H_PIX - 1);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_PIX + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_PIX + H_FP + H_PULSE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_FRAME - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_PIX);
    localparam logic [VW-1:0] V_VLAST  = VW'(V_PIX - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_PIX + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_PIX + V_FP + V_PULSE);
    localparam logic [HW-1:0] SZ_X     = HW'(SPR_SZ);
    localparam logic [VW-1:0] SZ_Y     = VW'(SPR_SZ);
    localparam logic [HW:0]   X_MAX    = (HW+1)'(H_PIX - SPR_SZ);
    localparam logic [VW:0]   Y_MAX    = (VW+1)'(V_PIX - SPR_SZ);
    localparam logic [HW:0]   STEP_X   = (HW+1)'(STEP);
    localparam logic [VW:0]   STEP_Y   = (VW+1)'(STEP);
    localparam logic [HW-1:0] X_INIT   = HW'(INIT_X);
    localparam logic [VW-1:0] Y_INIT   = VW'(INIT_Y);
    localparam logic [SW-1:0] COL_LAST = SW'(SPR_SZ - 1);

    // Direction per axis: two's-complement style encoding of -1/0/+1.
    typedef enum logic [1:0] {DIR_NONE = 2'b00, DIR_POS = 2'b01, DIR_NEG = 2'b11} dir_t;

    logic [DW-1:0]     div_q, div_d;
    logic [HW-1:0]     h_q, h_d, x_q, x_d;
    logic [VW-1:0]     v_q, v_d, y_q, y_d;
    dir_t              dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [SPR_SZ-1:0] bm_q [SPR_SZ];
    logic [3*CW-1:0]   pix_q, pix_d;
    logic              hs_q, hs_d, vs_q, vs_d, fs_q;

    logic              pix_en, fs_tick, visible, in_box, spr_on;
    logic [SW-1:0]     dx, dy;
    logic [SPR_SZ-1:0] row_bits;
    logic [HW:0]       x_ext;
    logic [VW:0]       y_ext;

    assign pix_en  = (div_q == DIV_LAST);
    assign fs_tick = pix_en && (h_q == '0) && (v_q == V_VIS);
    assign x_ext   = {1'b0, x_q};
    assign y_ext   = {1'b0, y_q};

    always_comb begin
        div_d = pix_en ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_comb begin
        visible  = (h_q < H_VIS) && (v_q < V_VIS);
        in_box   = (h_q >= x_q) && (h_q < x_q + SZ_X) && (v_q >= y_q) && (v_q < y_q + SZ_Y);
        dx       = SW'(h_q - x_q);
        dy       = SW'(v_q - y_q);
        row_bits = bm_q[dy];
        spr_on   = visible && in_box && row_bits[COL_LAST - dx];
        pix_d    = spr_on ? SPR_COLOR : '0;
`ifdef VGA_BORDER_EN
        if (visible && (h_q == '0 || h_q == H_VLAST || v_q == '0 || v_q == V_VLAST))
            pix_d = {{CW{1'b1}}, {(2*CW){1'b0}}};
`endif
        hs_d = (h_q >= HS_BEG && h_q < HS_END) ? H_POL : ~H_POL;
        vs_d = (v_q >= VS_BEG && v_q < VS_END) ? V_POL : ~V_POL;
    end

    // Motion uses the old direction; a coinciding key press then overrides the new direction.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (fs_tick) begin
            case (dir_x_q)
                DIR_POS: if (x_ext + STEP_X >= X_MAX) begin
                    x_d     = X_MAX[HW-1:0];
                    dir_x_d = bounce ? DIR_NEG : DIR_NONE;
                end else x_d = x_q + STEP_X[HW-1:0];
                DIR_NEG: if (x_ext <= STEP_X) begin
                    x_d     = '0;
                    dir_x_d = bounce ? DIR_POS : DIR_NONE;
                end else x_d = x_q - STEP_X[HW-1:0];
                default: ;
            endcase
            case (dir_y_q)
                DIR_POS: if (y_ext + STEP_Y >= Y_MAX) begin
                    y_d     = Y_MAX[VW-1:0];
                    dir_y_d = bounce ? DIR_NEG : DIR_NONE;
                end else y_d = y_q + STEP_Y[VW-1:0];
                DIR_NEG: if (y_ext <= STEP_Y) begin
                    y_d     = '0;
                    dir_y_d = bounce ? DIR_POS : DIR_NONE;
                end else y_d = y_q - STEP_Y[VW-1:0];
                default: ;
            endcase
        end
        if (key_valid && key_ext && !key_rel) begin
            case (key_code)
                8'h75: begin if (dir_y_q == DIR_NEG) dir_x_d = DIR_NONE; dir_y_d = DIR_NEG; end
                8'h72: begin if (dir_y_q == DIR_POS) dir_x_d = DIR_NONE; dir_y_d = DIR_POS; end
                8'h6B: begin if (dir_x_q == DIR_NEG) dir_y_d = DIR_NONE; dir_x_d = DIR_NEG; end
                8'h74: begin if (dir_x_q == DIR_POS) dir_y_d = DIR_NONE; dir_x_d = DIR_POS; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            x_q     <= X_INIT;
            y_q     <= Y_INIT;
            dir_x_q <= DIR_NONE;
            dir_y_q <= DIR_NONE;
            pix_q   <= '0;
            hs_q    <= ~H_POL;
            vs_q    <= ~V_POL;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            fs_q    <= fs_tick;
            if (pix_en) begin
                pix_q <= pix_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
            end
        end
    end

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            for (int i = 0; i < SPR_SZ; i++) bm_q[i] <= '0;
        end else if (bm_we && int'(bm_row) < SPR_SZ) begin
            bm_q[bm_row[SW-1:0]] <= bm_data;
        end
    end

    assign {vga_r, vga_g, vga_b} = pix_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign frame_start = fs_q;
endmodule
